// File: rtl/cfs_md_tx_serializer_if.sv
// MD TX transfer channel plus the byte stream it is serialized onto.
// The aligner (master) drives the MD request and the byte sink drives byte_ready;
// the serializer (slave) answers both.
interface cfs_md_tx_serializer_if #(
  parameter int ALGN_DATA_WIDTH = 32
);
  localparam int BYTES             = ALGN_DATA_WIDTH / 8;
  localparam int ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(BYTES);
  localparam int ALGN_SIZE_WIDTH   = $clog2(BYTES) + 1;

  logic                         md_valid;
  logic [ALGN_DATA_WIDTH-1:0]   md_data;
  logic [ALGN_OFFSET_WIDTH-1:0] md_offset;
  logic [ALGN_SIZE_WIDTH-1:0]   md_size;
  logic                         md_ready;
  logic                         md_err;

  logic                         byte_valid;
  logic [7:0]                   byte_data;
  logic                         byte_last;
  logic                         byte_ready;

  modport master (
    output md_valid, md_data, md_offset, md_size,
    input  md_ready, md_err,
    input  byte_valid, byte_data, byte_last,
    output byte_ready
  );

  modport slave (
    input  md_valid, md_data, md_offset, md_size,
    output md_ready, md_err,
    output byte_valid, byte_data, byte_last,
    input  byte_ready
  );
endinterface

// File: rtl/cfs_md_tx_serializer.sv
// Takes one aligned MD transfer at a time and replays its addressed bytes,
// lowest lane first, on a byte-wide valid/ready stream. The MD handshake is
// closed (md_ready/md_err) only after the last byte has left. Transfers whose
// offset/size do not fit in the word are answered with md_err and counted.
module cfs_md_tx_serializer #(
  parameter int ALGN_DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  cfs_md_tx_serializer_if.slave        bus,
  output logic [7:0]                   err_cnt
);
  localparam int BYTES             = ALGN_DATA_WIDTH / 8;
  localparam int ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(BYTES);
  localparam int ALGN_SIZE_WIDTH   = $clog2(BYTES) + 1;
  localparam int SUM_WIDTH         = ALGN_SIZE_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RESP
  } state_e;

  state_e                       state_q, state_d;
  logic [ALGN_DATA_WIDTH-1:0]   data_q, data_d;
  logic [ALGN_OFFSET_WIDTH-1:0] idx_q, idx_d;
  logic [ALGN_SIZE_WIDTH-1:0]   rem_q, rem_d;
  logic                         err_q, err_d;
  logic [7:0]                   err_cnt_q, err_cnt_d;

  logic                         md_ready_q, md_ready_d;
  logic                         md_err_q, md_err_d;
  logic                         byte_valid_q, byte_valid_d;
  logic [7:0]                   byte_data_q, byte_data_d;
  logic                         byte_last_q, byte_last_d;

  logic [SUM_WIDTH-1:0]         cap_end;
  logic                         cap_legal;
  logic [ALGN_OFFSET_WIDTH-1:0] idx_inc;

  // Pick byte lane idx out of a data word; idx is always a legal lane here.
  function automatic logic [7:0] lane_sel(input logic [ALGN_DATA_WIDTH-1:0]   data,
                                          input logic [ALGN_OFFSET_WIDTH-1:0] idx);
    logic [7:0] res;
    res = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (idx == ALGN_OFFSET_WIDTH'(k)) begin
        res = data[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Legality of the incoming request, summed one bit wider so it cannot overflow.
  always_comb begin
    cap_end   = SUM_WIDTH'(bus.md_offset) + SUM_WIDTH'(bus.md_size);
    cap_legal = (bus.md_size != '0) && (cap_end <= SUM_WIDTH'(BYTES));
    idx_inc   = idx_q + ALGN_OFFSET_WIDTH'(1);
  end

  // Next state and next registered outputs; outputs are precomputed so the
  // first byte is already visible in the cycle after capture.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    idx_d        = idx_q;
    rem_d        = rem_q;
    err_d        = err_q;
    err_cnt_d    = err_cnt_q;
    md_ready_d   = 1'b0;
    md_err_d     = 1'b0;
    byte_valid_d = 1'b0;
    byte_data_d  = 8'h00;
    byte_last_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.md_valid) begin
          data_d = bus.md_data;
          idx_d  = bus.md_offset;
          rem_d  = bus.md_size;
          if (cap_legal) begin
            state_d      = SEND;
            byte_valid_d = 1'b1;
            byte_data_d  = lane_sel(bus.md_data, bus.md_offset);
            byte_last_d  = (bus.md_size == ALGN_SIZE_WIDTH'(1));
          end else begin
            state_d    = RESP;
            err_d      = 1'b1;
            md_ready_d = 1'b1;
            md_err_d   = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end
        end
      end

      SEND: begin
        if (bus.byte_ready) begin
          if (rem_q == ALGN_SIZE_WIDTH'(1)) begin
            state_d    = RESP;
            err_d      = 1'b0;
            md_ready_d = 1'b1;
            md_err_d   = 1'b0;
          end else begin
            idx_d        = idx_inc;
            rem_d        = rem_q - ALGN_SIZE_WIDTH'(1);
            byte_valid_d = 1'b1;
            byte_data_d  = lane_sel(data_q, idx_inc);
            byte_last_d  = (rem_q == ALGN_SIZE_WIDTH'(2));
          end
        end else begin
          byte_valid_d = 1'b1;
          byte_data_d  = byte_data_q;
          byte_last_d  = byte_last_q;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture registers, error counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q       <= '0;
      idx_q        <= '0;
      rem_q        <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= 8'h00;
      md_ready_q   <= 1'b0;
      md_err_q     <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      byte_last_q  <= 1'b0;
    end else begin
      data_q       <= data_d;
      idx_q        <= idx_d;
      rem_q        <= rem_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      md_ready_q   <= md_ready_d;
      md_err_q     <= md_err_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_last_q  <= byte_last_d;
    end
  end

  assign bus.md_ready   = md_ready_q;
  assign bus.md_err     = md_err_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;
  assign bus.byte_last  = byte_last_q;
  assign err_cnt        = err_cnt_q;

endmodule

// File: doc/cfs_md_tx_serializer.md
Name: cfs_md_tx_serializer

Overview:
- Downstream consumer of the aligner's MD TX interface: the slave side of md_tx_valid/data/offset/size/ready/err.
- Accepts one aligned MD transfer at a time and emits the addressed bytes, lowest byte lane first, on a byte-wide valid/ready stream.
- Completes the MD handshake (md_ready, md_err) only after the last byte has been accepted. Illegal transfers are rejected with md_err.

Parameters:
- ALGN_DATA_WIDTH, 32: MD data width in bits; a multiple of 8, minimum 8. BYTES = ALGN_DATA_WIDTH/8.
- ALGN_OFFSET_WIDTH, derived (localparam): 1 when ALGN_DATA_WIDTH<=8, else $clog2(BYTES).
- ALGN_SIZE_WIDTH, derived (localparam): $clog2(BYTES)+1.

Ports:
- clk  input  1  single clock for all logic.
- reset_n  input  1  asynchronous active-low reset.
- md_valid  input  1  MD transfer request from the aligner TX side.
- md_data  input  ALGN_DATA_WIDTH  MD data; byte lane k = bits [8k+7:8k].
- md_offset  input  ALGN_OFFSET_WIDTH  first valid byte lane.
- md_size  input  ALGN_SIZE_WIDTH  number of valid bytes.
- md_ready  output  1  transfer-complete strobe.
- md_err  output  1  error response; meaningful only while md_ready=1.
- byte_valid  output  1  byte stream valid.
- byte_data  output  8  byte stream data.
- byte_last  output  1  marks the final byte of the current transfer.
- byte_ready  input  1  byte stream sink ready.
- err_cnt  output  8  saturating count of rejected transfers.

Behaviour:
- Reset values (async assert, sync release): state=IDLE.
  - md_ready, md_err, byte_valid, byte_last = 0.
  - byte_data = 0x00; err_cnt = 0.
  - Capture registers are cleared.
- All outputs are driven from registers; there is no combinational path from input to output.
- FSM states: IDLE, SEND, RESP.
- IDLE:
  - md_ready=0, byte_valid=0.
  - When md_valid=1 at a clock edge: capture md_data, md_offset and md_size.
  - Legality check, computed at width ALGN_SIZE_WIDTH+1 so the sum cannot overflow: legal when md_size!=0 and md_offset+md_size<=BYTES.
  - Legal: go to SEND with idx=md_offset and rem=md_size.
  - Illegal: go to RESP with err_q=1, and err_cnt increments (saturating at 255).
- SEND:
  - byte_valid=1, byte_data=lane[idx], byte_last=(rem==1).
  - On byte_valid && byte_ready: idx+1, rem-1. If byte_last, go to RESP with err_q=0.
  - Without byte_ready, byte_data and byte_last hold stable and byte_valid stays 1. The block never withdraws byte_valid.
- RESP:
  - md_ready=1 and md_err=err_q for exactly one cycle, then IDLE.
  - md_valid still high in RESP completes the MD transfer. md_valid is not re-sampled in RESP.
- Latency with byte_ready held at 1:
  - md_valid sampled at edge 0; first byte visible in cycle 1.
  - N-byte transfer: bytes in cycles 1..N, md_ready in cycle N+1, IDLE in cycle N+2.
  - The earliest next capture is at the end of cycle N+2.
- Illegal transfer: md_ready/md_err pulse in cycle 1 and byte_valid never asserts.
- md_valid dropping during SEND or RESP is a protocol violation. The block continues with the captured values and still issues md_ready.
- md_data, md_offset and md_size changing after capture have no effect.
- Reset asserted mid-SEND or mid-RESP: the transfer is abandoned and all outputs go to reset values immediately. No md_ready is issued for the abandoned transfer.
- idx never wraps, because legality guarantees idx stays <= BYTES-1.

Test Plan:
- Full-word transfer: md_data=0xDDCCBBAA, offset=0, size=4, byte_ready=1.
  - Bytes AA, BB, CC, DD in cycles 1-4, byte_last only on DD.
  - md_ready=1, md_err=0 in cycle 5 only.
- Partial transfer: md_data=0x44332211, offset=1, size=2.
  - Bytes 22 then 33, byte_last on 33.
  - md_ready=1, md_err=0 one cycle later; err_cnt stays 0.
- Backpressure: 0xDDCCBBAA/0/4 with byte_ready=0 for cycles 1-3.
  - byte_valid=1 and byte_data=AA hold stable through cycle 3.
  - Bytes BB, CC, DD follow in cycles 5-7; md_ready in cycle 8.
- Illegal transfers: offset=3/size=2, then offset=0/size=0.
  - Each gives no byte_valid, a one-cycle md_ready=1 with md_err=1, and one err_cnt increment.
  - err_cnt=2 after both.
- Saturation: 257 illegal transfers leave err_cnt=255.
  - A following legal 0xDDCCBBAA/0/4 transfer gives bytes AA, BB, CC, DD and md_err=0.
- Reset mid-SEND: assert reset_n=0 asynchronously after byte BB of a 4-byte transfer.
  - All outputs go to 0 at once; md_ready never pulses for that transfer.
  - After release, a new 0xDDCCBBAA/0/4 transfer emits AA, BB, CC, DD normally.
